// File: rtl/slow_clk_step_sync.sv
// slow_clk_step_sync: synchronizes the divided slow clock, turns its edges
// into ticks and converts ticks into req/ack generation-step requests.
// Optional feature macro: STEP_COUNT_EN adds a 16-bit step_count output.

module slow_clk_step_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic [CNT_W-1:0] divisor,
    input  logic             run,
    input  logic             single_step,
    input  logic             step_ack,
    input  logic             clear_overrun,
`ifdef STEP_COUNT_EN
    output logic [15:0]      step_count,
`endif
    output logic             tick,
    output logic             step_req,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;
    logic                   prev_q;
    logic                   prev_d;
    logic                   tick_q;
    logic                   tick_d;

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       div_eff;
    logic [CNT_W:0]         cnt_inc;
    logic                   auto_trig;
    logic                   trig;

    state_t                 state_q;
    logic                   step_req_q;
    logic                   overrun_q;
    logic                   overrun_d;

    // Shift slow_clk through the synchronizer chain and detect its rise.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], slow_clk};
        sync_out = sync_q[SYNC_STAGES-1];
        prev_d   = sync_out;
        tick_d   = sync_out & ~prev_q;
    end

    // Synchronizer, edge-detect and registered tick flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    // Count ticks against the live divisor; the extra bit avoids wrap.
    always_comb begin
        div_eff   = (divisor == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : divisor;
        cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        cnt_d     = cnt_q;
        auto_trig = 1'b0;
        if (tick_q && run) begin
            if (cnt_inc >= {1'b0, div_eff}) begin
                cnt_d     = '0;
                auto_trig = 1'b1;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
        trig = auto_trig | (single_step & ~run);
    end

    // Tick counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A trigger while a step is outstanding is dropped and flagged; set wins.
    always_comb begin
        overrun_d = overrun_q;
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (trig && state_q == REQ) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    // Step handshake FSM with registered step_req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            step_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q    <= REQ;
                        step_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (step_ack) begin
                        state_q    <= IDLE;
                        step_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    step_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_COUNT_EN
    logic [15:0] step_count_q;
    logic [15:0] step_count_d;

    // Count completed handshakes, wrapping naturally at 16 bits.
    always_comb begin
        step_count_d = step_count_q;
        if (state_q == REQ && step_ack) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    // Completed-step counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count_q <= 16'd0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    assign step_count = step_count_q;
`endif

    assign tick     = tick_q;
    assign step_req = step_req_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_slow_clk_step_sync.sv
// tb_slow_clk_step_sync: directed checks of tick sync, step handshake,
// pause/single-step, overrun and reset behaviour.

module tb_slow_clk_step_sync;

    logic       clk;
    logic       reset;
    logic       slow_clk;
    logic [7:0] divisor;
    logic       run;
    logic       single_step;
    logic       step_ack;
    logic       clear_overrun;
    logic       tick;
    logic       step_req;
    logic       overrun;
`ifdef STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    int n_cmp;
    int n_err;

    int cyc_n;
    int rise_at;
    int n_tick;
    int n_rise;
    int n_bad_rise;
    int lat_bad;
    int ack_dly;
    bit ack_en;
    bit clr_on_tick;
    bit tick_prev;
    bit req_prev;
    bit seen_tick;
    bit seen_req;
    bit seen_ovr;

    slow_clk_step_sync #(
        .SYNC_STAGES(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .slow_clk(slow_clk),
        .divisor(divisor),
        .run(run),
        .single_step(single_step),
        .step_ack(step_ack),
        .clear_overrun(clear_overrun),
`ifdef STEP_COUNT_EN
        .step_count(step_count),
`endif
        .tick(tick),
        .step_req(step_req),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic clr_stats();
        n_tick     = 0;
        n_rise     = 0;
        n_bad_rise = 0;
        lat_bad    = 0;
        seen_tick  = 0;
        seen_req   = 0;
        seen_ovr   = 0;
    endtask

    // One clk cycle: sample at negedge, update stats, drive auto-ack.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (tick) begin
            n_tick++;
            seen_tick = 1;
            if (cyc_n - rise_at < 2 || cyc_n - rise_at > 4) lat_bad++;
        end
        if (step_req) seen_req = 1;
        if (overrun) seen_ovr = 1;
        if (step_req && !req_prev) begin
            n_rise++;
            if (!tick_prev && !single_step) n_bad_rise++;
        end
        req_prev  = step_req;
        tick_prev = tick;
        if (ack_en) begin
            if (step_req) begin
                ack_dly++;
                step_ack = (ack_dly == 2);
            end else begin
                ack_dly  = 0;
                step_ack = 0;
            end
        end
        if (clr_on_tick) clear_overrun = tick;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    // n slow_clk periods of 16 clk: 8 high, 8 low.
    task automatic slow_periods(input int n);
        repeat (n) begin
            for (int i = 0; i < 16; i++) begin
                cyc();
                slow_clk = (i < 8);
                if (i == 0) rise_at = cyc_n;
            end
        end
    endtask

    task automatic pulse_single();
        cyc();
        single_step = 1;
        cyc();
        single_step = 0;
    endtask

    task automatic test_reset();
        reset         = 1;
        slow_clk      = 0;
        divisor       = 8'd3;
        run           = 1;
        single_step   = 0;
        step_ack      = 0;
        clear_overrun = 0;
        ack_en        = 0;
        clr_on_tick   = 0;
        cyc_n         = 0;
        rise_at       = -100;
        ack_dly       = 0;
        req_prev      = 0;
        tick_prev     = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tick, step_req, overrun} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 000",
                     {tick, step_req, overrun});
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", step_count);
        end
`endif
        reset = 0;
        clr_stats();
        cycles(100);
        n_cmp++;
        if ({seen_tick, seen_req, seen_ovr} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_quiet: got %b want 000",
                     {seen_tick, seen_req, seen_ovr});
        end
    endtask

    task automatic test_divisor3();
        divisor = 8'd3;
        run     = 1;
        ack_en  = 1;
        clr_stats();
        slow_periods(9);
        n_cmp++;
        if (n_tick !== 9) begin
            n_err++;
            $display("FAIL div3_ticks: got %0d want 9", n_tick);
        end
        n_cmp++;
        if (lat_bad !== 0) begin
            n_err++;
            $display("FAIL div3_latency: got %0d bad want 0", lat_bad);
        end
        n_cmp++;
        if (n_rise !== 3 || n_bad_rise !== 0) begin
            n_err++;
            $display("FAIL div3_steps: got %0d (%0d stray) want 3 (0)",
                     n_rise, n_bad_rise);
        end
        n_cmp++;
        if (seen_ovr !== 0 || step_req !== 0) begin
            n_err++;
            $display("FAIL div3_ovr: got ovr=%b req=%b want 0 0",
                     seen_ovr, step_req);
        end
    endtask

    task automatic test_divisor0();
        divisor = 8'd0;
        clr_stats();
        slow_periods(4);
        n_cmp++;
        if (n_rise !== 4 || n_tick !== 4 || seen_ovr !== 0) begin
            n_err++;
            $display("FAIL div0_steps: got %0d/%0d ovr=%b want 4/4 ovr=0",
                     n_rise, n_tick, seen_ovr);
        end
    endtask

    task automatic test_pause_single();
        divisor = 8'd3;
        run     = 0;
        clr_stats();
        slow_periods(5);
        n_cmp++;
        if (n_tick !== 5 || n_rise !== 0) begin
            n_err++;
            $display("FAIL pause_ticks: got %0d ticks %0d steps want 5 0",
                     n_tick, n_rise);
        end
        clr_stats();
        pulse_single();
        cycles(10);
        n_cmp++;
        if (n_rise !== 1 || n_bad_rise !== 0 || step_req !== 0) begin
            n_err++;
            $display("FAIL single_step: got %0d steps req=%b want 1 0",
                     n_rise, step_req);
        end
        run = 1;
        clr_stats();
        slow_periods(2);
        n_cmp++;
        if (n_rise !== 0) begin
            n_err++;
            $display("FAIL cnt_held_2: got %0d steps want 0", n_rise);
        end
        slow_periods(1);
        n_cmp++;
        if (n_rise !== 1) begin
            n_err++;
            $display("FAIL cnt_held_3: got %0d steps want 1", n_rise);
        end
        clr_stats();
        pulse_single();
        cycles(10);
        n_cmp++;
        if (n_rise !== 0) begin
            n_err++;
            $display("FAIL single_in_run: got %0d steps want 0", n_rise);
        end
    endtask

    task automatic test_overrun();
        divisor = 8'd1;
        ack_en  = 0;
        step_ack = 0;
        slow_periods(1);
        n_cmp++;
        if ({step_req, overrun} !== 2'b10) begin
            n_err++;
            $display("FAIL ovr_first: got %b want 10", {step_req, overrun});
        end
        slow_periods(1);
        n_cmp++;
        if ({step_req, overrun} !== 2'b11) begin
            n_err++;
            $display("FAIL ovr_second: got %b want 11", {step_req, overrun});
        end
        cyc();
        clear_overrun = 1;
        cyc();
        clear_overrun = 0;
        cyc();
        n_cmp++;
        if ({step_req, overrun} !== 2'b10) begin
            n_err++;
            $display("FAIL ovr_clear: got %b want 10", {step_req, overrun});
        end
        slow_periods(1);
        n_cmp++;
        if (overrun !== 1) begin
            n_err++;
            $display("FAIL ovr_again: got %b want 1", overrun);
        end
        cyc();
        clear_overrun = 1;
        cyc();
        clear_overrun = 0;
        clr_on_tick   = 1;
        slow_periods(1);
        clr_on_tick   = 0;
        clear_overrun = 0;
        cyc();
        n_cmp++;
        if (overrun !== 1) begin
            n_err++;
            $display("FAIL ovr_set_wins: got %b want 1", overrun);
        end
        ack_en = 1;
        cycles(10);
        ack_en   = 0;
        step_ack = 0;
        clear_overrun = 1;
        cyc();
        clear_overrun = 0;
        step_ack = 1;
        cycles(2);
        step_ack = 0;
        cyc();
        n_cmp++;
        if ({step_req, overrun} !== 2'b00) begin
            n_err++;
            $display("FAIL ack_idle: got %b want 00", {step_req, overrun});
        end
    endtask

    task automatic test_reset_mid();
        divisor = 8'd2;
        ack_en  = 0;
        slow_periods(2);
        n_cmp++;
        if (step_req !== 1) begin
            n_err++;
            $display("FAIL pre_reset_req: got %b want 1", step_req);
        end
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        n_cmp++;
        if (step_req !== 0) begin
            n_err++;
            $display("FAIL async_reset: got %b want 0", step_req);
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset_count: got %0d want 0", step_count);
        end
`endif
        repeat (2) @(negedge clk);
        reset    = 0;
        req_prev = 0;
        ack_en   = 1;
        clr_stats();
        cycles(20);
        n_cmp++;
        if (seen_req !== 0) begin
            n_err++;
            $display("FAIL no_replay: got %b want 0", seen_req);
        end
        slow_periods(1);
        n_cmp++;
        if (n_rise !== 0) begin
            n_err++;
            $display("FAIL div2_one_tick: got %0d steps want 0", n_rise);
        end
        slow_periods(1);
        n_cmp++;
        if (n_rise !== 1) begin
            n_err++;
            $display("FAIL div2_two_ticks: got %0d steps want 1", n_rise);
        end
        divisor = 8'd1;
        slow_periods(4);
        n_cmp++;
        if (n_rise !== 5) begin
            n_err++;
            $display("FAIL five_steps: got %0d want 5", n_rise);
        end
`ifdef STEP_COUNT_EN
        n_cmp++;
        if (step_count !== 16'd5) begin
            n_err++;
            $display("FAIL step_count5: got %0d want 5", step_count);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_divisor3();
        test_divisor0();
        test_pause_single();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
